exception_sequencer: RTL and testbench

Sequences the pipeline's response to exceptional events: an undecodable instruction flagged by the control unit in ID (WRONG_OP_CODE) and an arithmetic overflow flagged by the ALU in EX. It flushes the offending pipeline stages, records the faulting PC and cause, redirects fetch to the handler vector, and restores the saved PC on ERET. A second exception raised inside the handler is a double fault and halts the core until reset.

---
 rtl/exception_sequencer.sv | 178 +++++++++++++++++
 tb/tb_exception_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/exception_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exception_sequencer
//  Description : Sequences the pipeline response to an illegal opcode (ID) or
//                an ALU overflow (EX). It flushes the faulting stages, saves
//                the faulting PC and cause, redirects fetch to the handler
//                vector and restores the saved PC on ERET. A second exception
//                inside the handler is a double fault that halts the core.
//  Revision    : 1.0  initial release
// ============================================================================
module exception_sequencer #(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] VECTOR_ADDR  = 16'h00F0,
    parameter int                  FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wrong_op_code,
    input  logic                overflow,
    input  logic                eret,
    input  logic [PC_WIDTH-1:0] id_pc,
    input  logic [PC_WIDTH-1:0] ex_pc,
    output logic                flush_if,
    output logic                flush_id,
    output logic                flush_ex,
    output logic [1:0]          pc_sel,
    output logic [PC_WIDTH-1:0] epc,
    output logic [1:0]          cause,
    output logic                exc_active,
    output logic                halt,
    output logic [7:0]          exc_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH   = 3'd1,
        S_VECTOR  = 3'd2,
        S_HANDLER = 3'd3,
        S_RETURN  = 3'd4,
        S_HALTED  = 3'd5
    } state_t;

    localparam logic [1:0] c_PC_SEQ     = 2'b00;
    localparam logic [1:0] c_PC_VEC     = 2'b01;
    localparam logic [1:0] c_PC_EPC     = 2'b10;
    localparam logic [1:0] c_CAUSE_NONE = 2'b00;
    localparam logic [1:0] c_CAUSE_ILL  = 2'b01;
    localparam logic [1:0] c_CAUSE_OVF  = 2'b10;
    localparam logic [1:0] c_CAUSE_DBL  = 2'b11;
    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES);

    // The flush counter is 4 bits wide and instructions are halfword aligned,
    // so reject parameter sets the datapath cannot honour.
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || VECTOR_ADDR[0] != 1'b0) begin : g_param_check
        $error("exception_sequencer: FLUSH_CYCLES must be 1..15 and VECTOR_ADDR halfword aligned");
    end

    state_t             r_state;
    logic [3:0]         r_flush_cnt;
    logic               r_flush_if;
    logic               r_flush_id;
    logic               r_flush_ex;
    logic [1:0]         r_pc_sel;
    logic [PC_WIDTH-1:0] r_epc;
    logic [1:0]         r_cause;
    logic               r_exc_active;
    logic               r_halt;
    logic [7:0]         r_exc_count;

    logic               w_event;
    logic               w_detect;
    logic [7:0]         w_count_next;

    assign w_event      = overflow | wrong_op_code;
    // Detection-cycle flushes come straight from the inputs; held low in reset.
    assign w_detect     = rst_n & (r_state == S_IDLE) & w_event;
    assign w_count_next = (r_exc_count == 8'hFF) ? r_exc_count : r_exc_count + 8'd1;

    // Exception FSM; all outputs except the detection-cycle flushes are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_flush_cnt  <= 4'd0;
            r_flush_if   <= 1'b0;
            r_flush_id   <= 1'b0;
            r_flush_ex   <= 1'b0;
            r_pc_sel     <= c_PC_SEQ;
            r_epc        <= '0;
            r_cause      <= c_CAUSE_NONE;
            r_exc_active <= 1'b0;
            r_halt       <= 1'b0;
            r_exc_count  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_event) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= c_FLUSH_LOAD;
                        r_exc_count <= w_count_next;
                        r_flush_if  <= 1'b1;
                        r_flush_id  <= 1'b1;
                        // Overflow belongs to the older instruction, so it wins.
                        if (overflow) begin
                            r_epc      <= ex_pc;
                            r_cause    <= c_CAUSE_OVF;
                            r_flush_ex <= 1'b1;
                        end else begin
                            r_epc      <= id_pc;
                            r_cause    <= c_CAUSE_ILL;
                            r_flush_ex <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == 4'd1) begin
                        r_state    <= S_VECTOR;
                        r_flush_if <= 1'b0;
                        r_flush_id <= 1'b0;
                        r_flush_ex <= 1'b0;
                        r_pc_sel   <= c_PC_VEC;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                S_VECTOR: begin
                    r_state      <= S_HANDLER;
                    r_pc_sel     <= c_PC_SEQ;
                    r_exc_active <= 1'b1;
                end
                S_HANDLER: begin
                    if (w_event) begin
                        r_state      <= S_HALTED;
                        r_cause      <= c_CAUSE_DBL;
                        r_exc_count  <= w_count_next;
                        r_exc_active <= 1'b0;
                        r_halt       <= 1'b1;
                    end else if (eret) begin
                        r_state    <= S_RETURN;
                        r_pc_sel   <= c_PC_EPC;
                        r_flush_if <= 1'b1;
                        r_flush_id <= 1'b1;
                    end
                end
                S_RETURN: begin
                    r_state      <= S_IDLE;
                    r_pc_sel     <= c_PC_SEQ;
                    r_flush_if   <= 1'b0;
                    r_flush_id   <= 1'b0;
                    r_exc_active <= 1'b0;
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_flush_if   <= 1'b0;
                    r_flush_id   <= 1'b0;
                    r_flush_ex   <= 1'b0;
                    r_pc_sel     <= c_PC_SEQ;
                    r_exc_active <= 1'b0;
                    r_halt       <= 1'b0;
                end
            endcase
        end
    end

    assign flush_if   = r_flush_if | w_detect;
    assign flush_id   = r_flush_id | w_detect;
    assign flush_ex   = r_flush_ex | (w_detect & overflow);
    assign pc_sel     = r_pc_sel;
    assign epc        = r_epc;
    assign cause      = r_cause;
    assign exc_active = r_exc_active;
    assign halt       = r_halt;
    assign exc_count  = r_exc_count;

endmodule
`default_nettype wire

// File: tb/tb_exception_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exception_sequencer
//  Description : Self-checking bench for exception_sequencer: table of
//                per-cycle vectors plus directed reset and saturation runs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrong_op_code = 1'b0;
    logic        overflow = 1'b0;
    logic        eret = 1'b0;
    logic [15:0] id_pc = '0;
    logic [15:0] ex_pc = '0;
    logic        flush_if, flush_id, flush_ex;
    logic [1:0]  pc_sel;
    logic [15:0] epc;
    logic [1:0]  cause;
    logic        exc_active, halt;
    logic [7:0]  exc_count;
    logic [32:0] obs;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_cnt;

    typedef struct {
        logic        wop;
        logic        ovf;
        logic        ert;
        logic [15:0] ipc;
        logic [15:0] xpc;
        logic [32:0] exp;
    } vec_t;

    vec_t tbl [16];

    exception_sequencer #(
        .PC_WIDTH     (16),
        .VECTOR_ADDR  (16'h00F0),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wrong_op_code (wrong_op_code),
        .overflow      (overflow),
        .eret          (eret),
        .id_pc         (id_pc),
        .ex_pc         (ex_pc),
        .flush_if      (flush_if),
        .flush_id      (flush_id),
        .flush_ex      (flush_ex),
        .pc_sel        (pc_sel),
        .epc           (epc),
        .cause         (cause),
        .exc_active    (exc_active),
        .halt          (halt),
        .exc_count     (exc_count)
    );

    always #5 clk = ~clk;

    assign obs = {flush_if, flush_id, flush_ex, pc_sel, epc, cause, exc_active, halt, exc_count};

    // Packs {flush_if,flush_id,flush_ex,pc_sel,epc,cause,exc_active,halt,exc_count}.
    function automatic logic [32:0] pk(input logic fi, input logic fd, input logic fx,
                                       input logic [1:0] ps, input logic [15:0] e,
                                       input logic [1:0] c, input logic a, input logic h,
                                       input logic [7:0] n);
        return {fi, fd, fx, ps, e, c, a, h, n};
    endfunction

    function automatic vec_t mk(input logic w, input logic o, input logic r,
                                input logic [15:0] ip, input logic [15:0] xp,
                                input logic [32:0] e);
        vec_t v;
        v.wop = w; v.ovf = o; v.ert = r; v.ipc = ip; v.xpc = xp; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [32:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic o, input logic r,
                         input logic [15:0] ip, input logic [15:0] xp);
        wrong_op_code = w; overflow = o; eret = r; id_pc = ip; ex_pc = xp;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One illegal-opcode exception followed by ERET; optionally checks the idle state after.
    task automatic round_trip(input logic [15:0] pc, input logic do_check, input string name);
        int k;
        drive(1'b1, 1'b0, 1'b0, pc, 16'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        exp_cnt = (exp_cnt == 8'hFF) ? exp_cnt : exp_cnt + 8'd1;
        k = 0;
        while (!exc_active && k < 20) begin
            next_cycle();
            k++;
        end
        if (!exc_active) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: exc_active got 0 expected 1 within 20 cycles", name);
        end
        eret = 1'b1;
        next_cycle();
        eret = 1'b0;
        next_cycle();
        if (do_check) begin
            @(negedge clk);
            check(name, pk(1'b0, 1'b0, 1'b0, 2'b00, pc, 2'b01, 1'b0, 1'b0, exp_cnt));
            next_cycle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle-by-cycle scenario starting right after reset with FLUSH_CYCLES=2.
        tbl[0]  = mk(0, 0, 0, 16'h0000, 16'h0000, pk(0, 0, 0, 2'b00, 16'h0000, 2'b00, 0, 0, 8'd0));
        tbl[1]  = mk(1, 0, 0, 16'h0024, 16'h0000, pk(1, 1, 0, 2'b00, 16'h0000, 2'b00, 0, 0, 8'd0));
        tbl[2]  = mk(0, 1, 1, 16'h0030, 16'h0032, pk(1, 1, 0, 2'b00, 16'h0024, 2'b01, 0, 0, 8'd1));
        tbl[3]  = mk(1, 0, 0, 16'h0034, 16'h0000, pk(1, 1, 0, 2'b00, 16'h0024, 2'b01, 0, 0, 8'd1));
        tbl[4]  = mk(0, 0, 0, 16'h0000, 16'h0000, pk(0, 0, 0, 2'b01, 16'h0024, 2'b01, 0, 0, 8'd1));
        tbl[5]  = mk(0, 0, 0, 16'h0000, 16'h0000, pk(0, 0, 0, 2'b00, 16'h0024, 2'b01, 1, 0, 8'd1));
        tbl[6]  = mk(0, 0, 1, 16'h0000, 16'h0000, pk(0, 0, 0, 2'b00, 16'h0024, 2'b01, 1, 0, 8'd1));
        tbl[7]  = mk(0, 0, 0, 16'h0000, 16'h0000, pk(1, 1, 0, 2'b10, 16'h0024, 2'b01, 1, 0, 8'd1));
        tbl[8]  = mk(1, 1, 0, 16'h0012, 16'h0010, pk(1, 1, 1, 2'b00, 16'h0024, 2'b01, 0, 0, 8'd1));
        tbl[9]  = mk(0, 0, 0, 16'h0000, 16'h0000, pk(1, 1, 1, 2'b00, 16'h0010, 2'b10, 0, 0, 8'd2));
        tbl[10] = mk(0, 0, 0, 16'h0000, 16'h0000, pk(1, 1, 1, 2'b00, 16'h0010, 2'b10, 0, 0, 8'd2));
        tbl[11] = mk(0, 0, 0, 16'h0000, 16'h0000, pk(0, 0, 0, 2'b01, 16'h0010, 2'b10, 0, 0, 8'd2));
        tbl[12] = mk(0, 1, 1, 16'h0000, 16'h0050, pk(0, 0, 0, 2'b00, 16'h0010, 2'b10, 1, 0, 8'd2));
        tbl[13] = mk(0, 0, 0, 16'h0000, 16'h0000, pk(0, 0, 0, 2'b00, 16'h0010, 2'b11, 0, 1, 8'd3));
        tbl[14] = mk(1, 1, 1, 16'h0060, 16'h0062, pk(0, 0, 0, 2'b00, 16'h0010, 2'b11, 0, 1, 8'd3));
        tbl[15] = mk(0, 0, 0, 16'h0000, 16'h0000, pk(0, 0, 0, 2'b00, 16'h0010, 2'b11, 0, 1, 8'd3));

        // Reset held, then released; outputs must sit at reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_held", pk(0, 0, 0, 2'b00, 16'h0, 2'b00, 0, 0, 8'd0));
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle_%0d", i), pk(0, 0, 0, 2'b00, 16'h0, 2'b00, 0, 0, 8'd0));
            next_cycle();
        end

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].wop, tbl[i].ovf, tbl[i].ert, tbl[i].ipc, tbl[i].xpc);
            @(negedge clk);
            check($sformatf("vec_%0d", i), tbl[i].exp);
            next_cycle();
        end
        drive(0, 0, 0, 16'h0, 16'h0);

        // Asynchronous reset while halted clears everything at once.
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_in_halted", pk(0, 0, 0, 2'b00, 16'h0, 2'b00, 0, 0, 8'd0));
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Asynchronous reset in the middle of a flush.
        drive(1, 0, 0, 16'h0040, 16'h0);
        next_cycle();
        drive(0, 0, 0, 16'h0, 16'h0);
        #2;
        check("flush_before_reset", pk(1, 1, 0, 2'b00, 16'h0040, 2'b01, 0, 0, 8'd1));
        rst_n = 1'b0;
        #1;
        check("reset_in_flush", pk(0, 0, 0, 2'b00, 16'h0, 2'b00, 0, 0, 8'd0));
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Normal operation after reset, then saturation of the exception counter.
        exp_cnt = 8'd0;
        round_trip(16'h0080, 1'b1, "after_reset_trip");
        for (int t = 1; t <= 300; t++) begin
            round_trip(16'(16'h0100 + 2 * t),
                       (t == 1 || t == 253 || t == 254 || t == 255 || t == 300),
                       $sformatf("trip_%0d", t));
        end
        @(negedge clk);
        check("saturated", pk(0, 0, 0, 2'b00, 16'(16'h0100 + 600), 2'b01, 0, 0, 8'd255));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
